// File: rtl/seg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_capture
// Description : Recovers an 8-digit frame from a multiplexed 7-segment scan.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2097152
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [7:0]  an,
    input  logic [6:0]  seg,
    output logic [31:0] data,
    output logic [7:0]  glyph_err,
    output logic        frame_valid,
    output logic        an_err,
    output logic        stale
);

    localparam logic [7:0] c_STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam int         c_IDLE_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);

    logic [7:0]          r_an_meta, r_an_s;
    logic [6:0]          r_seg_meta, r_seg_s;
    logic [14:0]         r_pair_prev;
    logic [7:0]          r_stab_cnt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [7:0]          r_seen;
    logic [31:0]         r_shadow;
    logic [7:0]          r_shadow_err;
    logic [31:0]         r_data;
    logic [7:0]          r_glyph_err;
    logic                r_frame_valid;
    logic                r_an_err;
    logic                r_stale;

    logic [14:0] w_pair;
    logic        w_same;
    logic        w_accept;
    logic [7:0]  w_an_n;
    logic        w_onehot;
    logic        w_blank;
    logic        w_capture;
    logic        w_bad_an;
    logic        w_frame_done;
    logic        w_timeout;
    logic [2:0]  w_digit;
    logic [3:0]  w_nibble;
    logic        w_glyph_ok;
    logic [31:0] w_shadow_next;
    logic [7:0]  w_err_next;
    logic [7:0]  w_seen_next;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_an_meta  <= 8'hFF;
            r_an_s     <= 8'hFF;
            r_seg_meta <= 7'h7F;
            r_seg_s    <= 7'h7F;
        end else begin
            r_an_meta  <= an;
            r_an_s     <= r_an_meta;
            r_seg_meta <= seg;
            r_seg_s    <= r_seg_meta;
        end
    end

    assign w_pair   = {r_an_s, r_seg_s};
    assign w_same   = (w_pair == r_pair_prev);
    assign w_accept = w_same && (r_stab_cnt == c_STABLE_LAST);

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_pair_prev <= {8'hFF, 7'h7F};
            r_stab_cnt  <= 8'd0;
        end else begin
            r_pair_prev <= w_pair;
            if (!w_same)
                r_stab_cnt <= 8'd0;
            else if (r_stab_cnt != c_STABLE_MAX)
                r_stab_cnt <= r_stab_cnt + 8'd1;
        end
    end

    // Exactly one enable low: the inverted vector is a nonzero power of two.
    assign w_an_n    = ~r_an_s;
    assign w_onehot  = (w_an_n != 8'd0) && ((w_an_n & (w_an_n - 8'd1)) == 8'd0);
    assign w_blank   = (r_an_s == 8'hFF);
    assign w_capture = w_accept && w_onehot;
    assign w_bad_an  = w_accept && !w_onehot && !w_blank;

    always_comb begin
        w_digit = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_an_n[i])
                w_digit = 3'(i);
        end
    end

    always_comb begin
        w_glyph_ok = 1'b1;
        w_nibble   = 4'h0;
        case (r_seg_s)
            7'h40: w_nibble = 4'h0;
            7'h79: w_nibble = 4'h1;
            7'h24: w_nibble = 4'h2;
            7'h30: w_nibble = 4'h3;
            7'h19: w_nibble = 4'h4;
            7'h12: w_nibble = 4'h5;
            7'h02: w_nibble = 4'h6;
            7'h78: w_nibble = 4'h7;
            7'h00: w_nibble = 4'h8;
            7'h10: w_nibble = 4'h9;
            7'h08: w_nibble = 4'hA;
            7'h03: w_nibble = 4'hB;
            7'h46: w_nibble = 4'hC;
            7'h21: w_nibble = 4'hD;
            7'h06: w_nibble = 4'hE;
            7'h0E: w_nibble = 4'hF;
            default: w_glyph_ok = 1'b0;
        endcase
    end

    // Shadow contents as they would be after this capture; used for frame commit.
    always_comb begin
        w_shadow_next                      = r_shadow;
        w_shadow_next[{w_digit, 2'b00} +: 4] = w_nibble;
        w_err_next                         = r_shadow_err;
        w_err_next[w_digit]                = ~w_glyph_ok;
        w_seen_next                        = r_seen | w_an_n;
    end

    assign w_frame_done = w_capture && (w_seen_next == 8'hFF);
    assign w_timeout    = (r_idle_cnt == c_IDLE_LAST) && !w_capture;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_seen        <= 8'd0;
            r_shadow      <= 32'd0;
            r_shadow_err  <= 8'd0;
            r_data        <= 32'd0;
            r_glyph_err   <= 8'd0;
            r_frame_valid <= 1'b0;
            r_an_err      <= 1'b0;
            r_stale       <= 1'b1;
            r_idle_cnt    <= '0;
        end else begin
            r_frame_valid <= w_frame_done;
            r_an_err      <= w_bad_an;
            if (w_capture) begin
                r_shadow     <= w_shadow_next;
                r_shadow_err <= w_err_next;
                r_idle_cnt   <= '0;
                if (w_frame_done) begin
                    r_data      <= w_shadow_next;
                    r_glyph_err <= w_err_next;
                    r_seen      <= 8'd0;
                    r_stale     <= 1'b0;
                end else begin
                    r_seen <= w_seen_next;
                end
            end else if (w_timeout) begin
                r_seen     <= 8'd0;
                r_stale    <= 1'b1;
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
            end
        end
    end

    assign data        = r_data;
    assign glyph_err   = r_glyph_err;
    assign frame_valid = r_frame_valid;
    assign an_err      = r_an_err;
    assign stale       = r_stale;

endmodule
`default_nettype wire

// File: doc/seg_scan_capture.md
SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 Parameters SHALL be, one per line:
- STABLE_CYCLES, 16, consecutive identical samples required to accept a digit (range 2..255).
- TIMEOUT_CYCLES, 2097152, idle cycles without an accepted digit before the partial frame is discarded.
REQ-002 Ports SHALL be, one per line:
- CLK100MHZ  input  1  sole clock, all flops on rising edge.
- reset  input  1  asynchronous, active-high.
- an  input  8  digit enables, active-low, asynchronous to the block.
- seg  input  7  segment pattern, active-low, asynchronous to the block.
- data  output  32  last complete frame; nibble k is digit k.
- glyph_err  output  8  per-digit mask of undecodable patterns in the last frame.
- frame_valid  output  1  one-cycle pulse when data/glyph_err update.
- an_err  output  1  one-cycle pulse on a stable an value that is not one-hot-low.
- stale  output  1  level: no complete frame since reset or since last timeout.

Function
REQ-003 an and seg SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized pair {an_s, seg_s}.
REQ-004 A stability counter SHALL clear when {an_s, seg_s} differs from its previous-cycle value and increment otherwise, saturating at STABLE_CYCLES.
REQ-005 An accept event SHALL occur on the single cycle the counter reaches STABLE_CYCLES; no further accept until the pair changes again.
REQ-006 On accept with an_s one-hot-low (bit k = 0, others 1): digit k is captured; set seen[k].
REQ-007 On accept with an_s = 8'hFF (blank): no capture, no error.
REQ-008 On accept with any other an_s: no capture; an_err pulses 1 on the following cycle.
REQ-009 Decode of seg_s SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F (7-bit hex, bit 6..0 = g..a).
REQ-010 Any other pattern SHALL store nibble 0 for digit k and set shadow error bit k; a valid pattern clears shadow error bit k.
REQ-011 Re-accept of a digit already in seen SHALL overwrite its shadow nibble and error bit; no error.
REQ-012 When an accept makes seen == 8'hFF, on that edge: data <= shadow including the new nibble; glyph_err <= shadow errors including the new bit; seen <= 0; frame_valid = 1 for exactly the next cycle; stale <= 0.
REQ-013 data and glyph_err SHALL change only per REQ-012 or reset.
REQ-014 An idle counter SHALL clear on every capture (REQ-006) and increment otherwise; on reaching TIMEOUT_CYCLES: seen <= 0, stale <= 1, counter clears. data is retained.
REQ-015 Timeout and a capture on the same cycle: capture wins, counter clears, no discard.
REQ-016 Scan order is irrelevant; any order covering all eight digits completes a frame.

Reset
REQ-017 Asserting reset at any time, including mid-frame, SHALL immediately force: data = 0, glyph_err = 0, frame_valid = 0, an_err = 0, stale = 1, seen = 0, shadow = 0, both counters = 0, synchronizer flops = {8'hFF, 7'h7F}.
REQ-018 After reset deasserts, the first frame_valid SHALL require eight fresh captures.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Scan digits 0..7 showing 0x1234ABCD (each held 40 cycles, STABLE_CYCLES = 16) -> one frame_valid pulse, data = 32'h1234ABCD, glyph_err = 0, stale = 0.
- Digit 3 driven with seg = 7'h7E, rest valid -> data[15:12] = 0, glyph_err = 8'h08.
- an = 8'b11110011 held 40 cycles -> exactly one an_err pulse, seen unchanged.
- A glitch shorter than 16 cycles between digits, scanned 7,6,...,0 -> no spurious capture; data correct; frame_valid once.
- Seven digits scanned, then idle for TIMEOUT_CYCLES (set to 1000) -> stale = 1, data unchanged; next full scan -> frame_valid.
- reset pulsed after four digits -> all outputs at reset values; four more digits give no frame_valid.
